// File: rtl/wishbone_package.sv
// Shared Wishbone widths, direction constants and the arbiter FSM state type.
package wishbone_package;

  localparam int unsigned WB_ADDR_WIDTH = 10;
  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_SEL_WIDTH  = 4;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } arb_state_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin grant: the search starts at i_ptr and wraps around.
module wb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  int unsigned w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_j = (32'(i_ptr) + i) % NUM_REQ;
      if (o_gnt == '0 && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/wb_ms_arbiter.sv
// Round-robin sharing of one Wishbone slave port among NUM_REQ requesters, one
// single-beat classic cycle at a time, with a watchdog on missing ack/err.
module wb_ms_arbiter
  import wishbone_package::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADR_W   = WB_ADDR_WIDTH,
  parameter int unsigned DAT_W   = WB_DATA_WIDTH,
  parameter int unsigned SEL_W   = WB_SEL_WIDTH,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [NUM_REQ*ADR_W-1:0]   adr_i,
  input  logic [NUM_REQ*DAT_W-1:0]   dat_i,
  input  logic [NUM_REQ*SEL_W-1:0]   sel_i,
  output logic [NUM_REQ-1:0]         done_o,
  output logic [DAT_W-1:0]           rdat_o,
  output logic                       err_o,
  output logic                       tmo_o,
  output logic [ADR_W-1:0]           wb_adr_o,
  output logic [DAT_W-1:0]           wb_dat_o,
  output logic [SEL_W-1:0]           wb_sel_o,
  output logic                       wb_we_o,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  input  logic [DAT_W-1:0]           wb_dat_i,
  input  logic                       wb_ack_i,
  input  logic                       wb_err_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt, r_win, w_win_nxt, w_idx;
  logic [NUM_REQ-1:0] r_win_oh, w_win_oh_nxt, w_gnt;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic [ADR_W-1:0]   r_adr, w_adr_nxt;
  logic [DAT_W-1:0]   r_dat, w_dat_nxt, r_rdat, w_rdat_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic               r_we, w_we_nxt, r_cyc, w_cyc_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic               r_err, w_err_nxt, r_tmo, w_tmo_nxt, w_fin;

  wb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req (req_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_win_nxt    = r_win;
    w_win_oh_nxt = r_win_oh;
    w_cnt_nxt    = r_cnt;
    w_adr_nxt    = r_adr;
    w_dat_nxt    = r_dat;
    w_sel_nxt    = r_sel;
    w_we_nxt     = r_we;
    w_cyc_nxt    = r_cyc;
    w_rdat_nxt   = r_rdat;
    w_done_nxt   = '0;
    w_err_nxt    = 1'b0;
    w_tmo_nxt    = 1'b0;
    w_fin        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_win_nxt    = w_idx;
          w_win_oh_nxt = w_gnt;
          w_adr_nxt    = adr_i[w_idx*ADR_W +: ADR_W];
          w_dat_nxt    = dat_i[w_idx*DAT_W +: DAT_W];
          w_sel_nxt    = sel_i[w_idx*SEL_W +: SEL_W];
          w_we_nxt     = we_i[w_idx];
          w_cyc_nxt    = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = BUS;
        end
      end
      BUS: begin
        // Error takes priority when ack and err arrive together.
        if (wb_err_i) begin
          w_err_nxt = 1'b1;
          w_fin     = 1'b1;
        end else if (wb_ack_i) begin
          if (r_we == READ) w_rdat_nxt = wb_dat_i;
          w_fin = 1'b1;
        end else if (r_cnt == 8'(TMO_CYC - 1)) begin
          w_err_nxt = 1'b1;
          w_tmo_nxt = 1'b1;
          w_fin     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
        if (w_fin) begin
          w_cyc_nxt   = 1'b0;
          w_done_nxt  = r_win_oh;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Pointer holds the next search start, i.e. the slot after the winner.
        w_ptr_nxt   = (32'(r_win) == NUM_REQ - 1) ? '0 : r_win + IDX_W'(1);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_win_oh <= '0;
      r_cnt    <= '0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_cyc    <= 1'b0;
      r_rdat   <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_win    <= w_win_nxt;
      r_win_oh <= w_win_oh_nxt;
      r_cnt    <= w_cnt_nxt;
      r_adr    <= w_adr_nxt;
      r_dat    <= w_dat_nxt;
      r_sel    <= w_sel_nxt;
      r_we     <= w_we_nxt;
      r_cyc    <= w_cyc_nxt;
      r_rdat   <= w_rdat_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_tmo    <= w_tmo_nxt;
    end
  end

  assign done_o   = r_done;
  assign rdat_o   = r_rdat;
  assign err_o    = r_err;
  assign tmo_o    = r_tmo;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign wb_sel_o = r_sel;
  assign wb_we_o  = r_we;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_cyc;

endmodule
